// File: rtl/time_keeper_pkg.sv
// time_keeper_pkg: time field widths, limits and the 12 h display mapping.
package time_keeper_pkg;
  localparam int TIME_W = 7;
  localparam logic [TIME_W-1:0] HH_MAX = 7'd23;
  localparam logic [TIME_W-1:0] MM_MAX = 7'd59;
  localparam logic [TIME_W-1:0] SS_MAX = 7'd59;
  localparam logic [TIME_W-1:0] HALF_DAY = 7'd12;
  function automatic logic [TIME_W-1:0] to_12h(input logic [TIME_W-1:0] h);
    return h == '0 ? HALF_DAY : h > HALF_DAY ? h - HALF_DAY : h;
  endfunction
endpackage

// File: rtl/time_keeper_tick_divider.sv
// tick_divider: divides the system clock into a one-cycle tick every PRESCALE
// running cycles; clear restarts the count from zero.
module tick_divider #(
  parameter int PRESCALE = 2000000,
  parameter int PS_W = 21
) (
  input  logic clk_2MHz,
  input  logic reset_n,
  input  logic run,
  input  logic clear,
  output logic tick
);
  localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);
  logic [PS_W-1:0] r_cnt;
  assign tick = run && r_cnt == LAST;
  always_ff @(posedge clk_2MHz or negedge reset_n)
    if (!reset_n) r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else if (run) r_cnt <= tick ? '0 : r_cnt + PS_W'(1);
endmodule

// File: rtl/time_keeper.sv
// time_keeper: HH:MM:SS time base with validated load and tick/wrap/error pulses.
// TIME_KEEPER_AP12_EN selects 12 h display output with PM flag.
module time_keeper
  import time_keeper_pkg::*;
#(
  parameter int PRESCALE = 2000000,
  parameter int PS_W = 21
) (
  input  logic              clk_2MHz,
  input  logic              reset_n,
  input  logic              load,
  input  logic [TIME_W-1:0] in_hh,
  input  logic [TIME_W-1:0] in_mm,
  input  logic [TIME_W-1:0] in_ss,
  input  logic              run,
  output logic [TIME_W-1:0] out_hh,
  output logic [TIME_W-1:0] out_mm,
  output logic [TIME_W-1:0] out_ss,
  output logic              sec_tick,
  output logic              day_wrap,
  output logic              load_err,
  output logic [TIME_W-1:0] disp_hh,
  output logic              disp_pm
);
  logic [TIME_W-1:0] r_hh, r_mm, r_ss;
  logic r_sec_tick, r_day_wrap, r_load_err;
  logic w_valid, w_ld, w_tick, w_adv, w_ss_wrap, w_mm_wrap, w_hh_wrap;
  assign w_valid = in_hh <= HH_MAX && in_mm <= MM_MAX && in_ss <= SS_MAX;
  assign w_ld = load && w_valid;
  assign w_adv = w_tick && !w_ld;
  assign w_ss_wrap = r_ss == SS_MAX;
  assign w_mm_wrap = r_mm == MM_MAX;
  assign w_hh_wrap = r_hh == HH_MAX;
  tick_divider #(.PRESCALE(PRESCALE), .PS_W(PS_W)) u_div (
    .clk_2MHz(clk_2MHz),
    .reset_n (reset_n),
    .run     (run),
    .clear   (w_ld),
    .tick    (w_tick)
  );
  always_ff @(posedge clk_2MHz or negedge reset_n)
    if (!reset_n) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
      r_sec_tick <= 1'b0;
      r_day_wrap <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_sec_tick <= w_adv;
      r_day_wrap <= w_adv && w_ss_wrap && w_mm_wrap && w_hh_wrap;
      r_load_err <= load && !w_valid;
      if (w_ld) begin
        r_hh <= in_hh;
        r_mm <= in_mm;
        r_ss <= in_ss;
      end else if (w_tick) begin
        r_ss <= w_ss_wrap ? '0 : r_ss + 7'd1;
        if (w_ss_wrap) r_mm <= w_mm_wrap ? '0 : r_mm + 7'd1;
        if (w_ss_wrap && w_mm_wrap) r_hh <= w_hh_wrap ? '0 : r_hh + 7'd1;
      end
    end
  assign out_hh = r_hh;
  assign out_mm = r_mm;
  assign out_ss = r_ss;
  assign sec_tick = r_sec_tick;
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;
`ifdef TIME_KEEPER_AP12_EN
  assign disp_hh = to_12h(r_hh);
  assign disp_pm = r_hh >= HALF_DAY;
`else
  assign disp_hh = r_hh;
  assign disp_pm = 1'b0;
`endif
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed bench with a seconds-of-day reference model, PRESCALE=4.
module tb_time_keeper;
  logic clk = 1'b0;
  logic reset_n, load, run;
  logic [6:0] in_hh, in_mm, in_ss;
  logic [6:0] out_hh, out_mm, out_ss, disp_hh;
  logic sec_tick, day_wrap, load_err, disp_pm;
  int checks = 0, failures = 0;
  int m_t, m_ph, n_tick, n_wrap;
  logic e_tick, e_wrap, e_err;
  always #5 clk = ~clk;
  time_keeper #(.PRESCALE(4), .PS_W(3)) dut (
    .clk_2MHz(clk), .reset_n(reset_n), .load(load), .in_hh(in_hh), .in_mm(in_mm),
    .in_ss(in_ss), .run(run), .out_hh(out_hh), .out_mm(out_mm), .out_ss(out_ss),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err),
    .disp_hh(disp_hh), .disp_pm(disp_pm)
  );
  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_t = 0; m_ph = 0; e_tick = 0; e_wrap = 0; e_err = 0;
    end else begin
      e_err = load && !(in_hh < 24 && in_mm < 60 && in_ss < 60);
      if (load && !e_err) begin
        m_t = in_hh * 3600 + in_mm * 60 + in_ss;
        m_ph = 0; e_tick = 0; e_wrap = 0;
      end else begin
        e_tick = run && m_ph == 3;
        e_wrap = e_tick && m_t == 86399;
        if (run) m_ph = (m_ph + 1) % 4;
        if (e_tick) m_t = (m_t + 1) % 86400;
      end
    end
  function automatic int exp_disp(input int h);
`ifdef TIME_KEEPER_AP12_EN
    return h == 0 ? 12 : h > 12 ? h - 12 : h;
`else
    return h;
`endif
  endfunction
  function automatic int exp_pm(input int h);
`ifdef TIME_KEEPER_AP12_EN
    return h >= 12 ? 1 : 0;
`else
    return 0 * h;
`endif
  endfunction
  always @(negedge clk) begin
    chk("hh", out_hh, m_t / 3600);
    chk("mm", out_mm, (m_t / 60) % 60);
    chk("ss", out_ss, m_t % 60);
    chk("sec_tick", sec_tick, e_tick);
    chk("day_wrap", day_wrap, e_wrap);
    chk("load_err", load_err, e_err);
    chk("disp_hh", disp_hh, exp_disp(m_t / 3600));
    chk("disp_pm", disp_pm, exp_pm(m_t / 3600));
  end
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_tick += sec_tick;
      n_wrap += day_wrap;
    end
  endtask
  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1; in_hh = 7'(h); in_mm = 7'(m); in_ss = 7'(s);
    step(1);
    load = 1'b0;
  endtask
  task automatic chk_time(input string n, input int h, input int m, input int s);
    chk({n, "_hh"}, out_hh, h);
    chk({n, "_mm"}, out_mm, m);
    chk({n, "_ss"}, out_ss, s);
  endtask
  initial begin
    reset_n = 1'b0; run = 1'b0; load = 1'b0; in_hh = '0; in_mm = '0; in_ss = '0;
    n_tick = 0; n_wrap = 0;
    step(2);
    chk_time("rst", 0, 0, 0);
    reset_n = 1'b1; run = 1'b1;
    n_tick = 0;
    step(12);
    chk("run12_ss", out_ss, 3);
    chk("run12_ticks", n_tick, 3);
    chk("run12_tick_now", sec_tick, 1);
    do_load(23, 59, 58);
    chk_time("ld", 23, 59, 58);
    n_wrap = 0;
    step(8);
    chk_time("wrap", 0, 0, 0);
    chk("wrap_now", day_wrap, 1);
    chk("wrap_count", n_wrap, 1);
    run = 1'b0;
    do_load(10, 20, 30);
    do_load(24, 0, 0);
    chk("bad_err", load_err, 1);
    chk_time("bad", 10, 20, 30);
    step(1);
    chk("bad_err_gone", load_err, 0);
    run = 1'b1;
    step(3);
    do_load(1, 2, 3);
    chk_time("coll", 1, 2, 3);
    chk("coll_tick", sec_tick, 0);
    step(3);
    chk("coll_ss3", out_ss, 3);
    chk("coll_notick", sec_tick, 0);
    step(1);
    chk("coll_ss4", out_ss, 4);
    chk("coll_tick4", sec_tick, 1);
    step(2);
    run = 1'b0;
    n_tick = 0;
    step(10);
    chk("frz_ss", out_ss, 4);
    chk("frz_ticks", n_tick, 0);
    run = 1'b1;
    step(1);
    chk("frz_phase_hold", sec_tick, 0);
    step(1);
    chk("frz_phase_tick", sec_tick, 1);
    chk("frz_ss5", out_ss, 5);
    run = 1'b0;
    do_load(0, 30, 0);
`ifdef TIME_KEEPER_AP12_EN
    chk("ap_00_hh", disp_hh, 12);
`else
    chk("ap_00_hh", disp_hh, 0);
`endif
    chk("ap_00_pm", disp_pm, 0);
    do_load(13, 0, 0);
`ifdef TIME_KEEPER_AP12_EN
    chk("ap_13_hh", disp_hh, 1);
    chk("ap_13_pm", disp_pm, 1);
`else
    chk("ap_13_hh", disp_hh, 13);
    chk("ap_13_pm", disp_pm, 0);
`endif
    run = 1'b1;
    do_load(5, 6, 7);
    step(2);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_time("arst", 0, 0, 0);
    chk("arst_tick", sec_tick, 0);
    chk("arst_wrap", day_wrap, 0);
    chk("arst_err", load_err, 0);
    step(2);
    reset_n = 1'b1;
    step(3);
    chk("rel_ss", out_ss, 0);
    chk("rel_tick", sec_tick, 0);
    step(1);
    chk("rel_ss1", out_ss, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
